// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan driver.
//   SEG_BLANK  - all segments off (active-low)
//   SEG_0..F   - active-low {a,b,c,d,e,f,g} patterns for hex digits
//   hex_to_seg - nibble to active-low segment pattern
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-low segment decoder.
//   nibble_i - hex value to display
//   seg_n_o  - active-low segments {a,b,c,d,e,f,g}
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = hex_to_seg(nibble_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an N-digit common-anode
// seven-segment display with frame-atomic updates and leading-zero blanking.
//   clk         - system clock
//   rst_n       - synchronous active-low reset
//   data_in     - packed hex nibbles, nibble k drives digit k
//   dp_in       - per-digit decimal point request, active-high
//   lz_en       - leading-zero blanking enable
//   load        - strobe capturing data_in/dp_in into the pending register
//   upd_pending - a loaded value is waiting for the next frame boundary
//   seg_n       - active-low segments {a..g}, registered
//   dp_n        - active-low decimal point, registered
//   an_n        - active-low one-hot digit enables, registered
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned CNT_W      = $clog2(SCAN_DIV),
  parameter int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  input  logic                    load,
  output logic                    upd_pending,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d, next_idx;
  logic                    tick, frame_end;

  logic [4*NUM_DIGITS-1:0] act_q, act_d, pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                    upd_q, upd_d;

  logic [6:0]              seg_q, seg_d, dec_seg;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic [3:0]              sel_nib;
  logic                    sel_dp, sel_blank, zero_run;

  // Divider, index and load handshake.
  always_comb begin
    tick      = (div_cnt_q == CNT_LAST);
    frame_end = tick && (idx_q == IDX_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + CNT_W'(1);
    next_idx  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    idx_d     = tick ? next_idx : idx_q;

    pend_d    = pend_q;
    pend_dp_d = pend_dp_q;
    act_d     = act_q;
    act_dp_d  = act_dp_q;
    upd_d     = upd_q;

    if (load) begin
      pend_d    = data_in;
      pend_dp_d = dp_in;
      upd_d     = 1'b1;
    end

    // A load coinciding with the frame boundary bypasses pending entirely.
    if (frame_end) begin
      if (load) begin
        act_d    = data_in;
        act_dp_d = dp_in;
        upd_d    = 1'b0;
      end else if (upd_q) begin
        act_d    = pend_q;
        act_dp_d = pend_dp_q;
        upd_d    = 1'b0;
      end
    end
  end

  // Digit selection reads act_d so that digit 0 at a frame boundary shows
  // the value being committed on that same edge. Blanking scans from the
  // most significant digit down, tracking whether everything above is zero.
  always_comb begin
    sel_nib   = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    zero_run  = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      int unsigned k;
      k        = NUM_DIGITS - 1 - i;
      zero_run = zero_run & (act_d[4*k +: 4] == 4'h0);
      if (IDX_W'(k) == next_idx) begin
        sel_nib   = act_d[4*k +: 4];
        sel_dp    = act_dp_d[k];
        sel_blank = lz_en && zero_run && (k != 0);
      end
    end
  end

  seg7_decode u_decode (
    .nibble_i (sel_nib),
    .seg_n_o  (dec_seg)
  );

  always_comb begin
    seg_d = seg_q;
    dp_d  = dp_q;
    an_d  = an_q;
    if (tick) begin
      seg_d = sel_blank ? SEG_BLANK : dec_seg;
      dp_d  = ~sel_dp;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (IDX_W'(i) != next_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      act_q     <= '0;
      act_dp_q  <= '0;
      pend_q    <= '0;
      pend_dp_q <= '0;
      upd_q     <= 1'b0;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      an_q      <= '1;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      act_q     <= act_d;
      act_dp_q  <= act_dp_d;
      pend_q    <= pend_d;
      pend_dp_q <= pend_dp_d;
      upd_q     <= upd_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign upd_pending = upd_q;
  assign seg_n       = seg_q;
  assign dp_n        = dp_q;
  assign an_n        = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed self-checking bench for seg7_scan_driver
// with NUM_DIGITS=4, SCAN_DIV=4. Inputs are driven and outputs sampled on
// the falling edge; step numbers below are falling-edge indices.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic        load;
  logic        upd_pending;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  int unsigned ncnt        = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .lz_en       (lz_en),
    .load        (load),
    .upd_pending (upd_pending),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n)
  );

  task automatic wait_neg(input int unsigned n);
    while (ncnt < n) begin
      @(negedge clk);
      ncnt++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] an_e,
                          input logic [6:0] seg_e, input logic dp_e);
    chk({tag, ".an"},  32'(an_n),  32'(an_e));
    chk({tag, ".seg"}, 32'(seg_n), 32'(seg_e));
    chk({tag, ".dp"},  32'(dp_n),  32'(dp_e));
  endtask

  initial begin
    rst_n   = 1'b0;
    data_in = '0;
    dp_in   = '0;
    lz_en   = 1'b0;
    load    = 1'b0;

    // Reset held for three edges, then released.
    wait_neg(3);
    chk_disp("rst", 4'hF, 7'h7F, 1'b1);
    chk("rst.upd", 32'(upd_pending), 32'd0);
    rst_n = 1'b1;
    wait_neg(4);  chk_disp("dark1", 4'hF, 7'h7F, 1'b1);
    wait_neg(5);  chk_disp("dark2", 4'hF, 7'h7F, 1'b1);
    wait_neg(6);  chk_disp("dark3", 4'hF, 7'h7F, 1'b1);
    wait_neg(7);  chk_disp("first_d1", 4'b1101, 7'b0000001, 1'b1);

    // Load 12AF with dp on digit 2.
    data_in = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
    wait_neg(8);  load = 1'b0;
    chk("ld1.upd", 32'(upd_pending), 32'd1);
    wait_neg(18);
    chk("ld1.upd_hold", 32'(upd_pending), 32'd1);
    chk_disp("ld1.old_d3", 4'b0111, 7'b0000001, 1'b1);
    wait_neg(19);
    chk("ld1.upd_clr", 32'(upd_pending), 32'd0);
    chk_disp("ld1.d0", 4'b1110, 7'b0111000, 1'b1);
    wait_neg(23); chk_disp("ld1.d1", 4'b1101, 7'b0001000, 1'b1);
    wait_neg(27); chk_disp("ld1.d2", 4'b1011, 7'b0010010, 1'b0);
    wait_neg(31); chk_disp("ld1.d3", 4'b0111, 7'b1001111, 1'b1);

    // Two loads mid-frame: last wins, nothing changes until frame end.
    data_in = 16'h1111; dp_in = 4'b0000; load = 1'b1;
    wait_neg(32); load = 1'b0;
    chk("atom.upd", 32'(upd_pending), 32'd1);
    wait_neg(33); data_in = 16'h2222; load = 1'b1;
    wait_neg(34); load = 1'b0;
    chk_disp("atom.hold_d3", 4'b0111, 7'b1001111, 1'b1);
    wait_neg(35);
    chk("atom.upd_clr", 32'(upd_pending), 32'd0);
    chk_disp("atom.d0", 4'b1110, 7'b0010010, 1'b1);
    wait_neg(39); chk_disp("atom.d1", 4'b1101, 7'b0010010, 1'b1);
    wait_neg(43); chk_disp("atom.d2", 4'b1011, 7'b0010010, 1'b1);
    wait_neg(47); chk_disp("atom.d3", 4'b0111, 7'b0010010, 1'b1);

    // Load on the frame_end edge goes straight to active.
    wait_neg(50);
    chk("fe.upd_before", 32'(upd_pending), 32'd0);
    data_in = 16'h0005; dp_in = 4'b0000; load = 1'b1;
    wait_neg(51); load = 1'b0;
    chk("fe.upd", 32'(upd_pending), 32'd0);
    chk_disp("fe.d0", 4'b1110, 7'b0100100, 1'b1);
    wait_neg(55); chk_disp("fe.d1_nolz", 4'b1101, 7'b0000001, 1'b1);

    // Leading-zero blanking; applies immediately to current active 0005.
    data_in = 16'h0050; dp_in = 4'b1000; lz_en = 1'b1; load = 1'b1;
    wait_neg(56); load = 1'b0;
    wait_neg(59); chk_disp("lz5.d2", 4'b1011, 7'h7F, 1'b1);
    wait_neg(63); chk_disp("lz5.d3", 4'b0111, 7'h7F, 1'b1);
    wait_neg(67); chk_disp("lz50.d0", 4'b1110, 7'b0000001, 1'b1);
    wait_neg(71); chk_disp("lz50.d1", 4'b1101, 7'b0100100, 1'b1);
    wait_neg(75); chk_disp("lz50.d2", 4'b1011, 7'h7F, 1'b1);
    wait_neg(79); chk_disp("lz50.d3_dp", 4'b0111, 7'h7F, 1'b0);

    data_in = 16'h0000; dp_in = 4'b0000; load = 1'b1;
    wait_neg(80); load = 1'b0;
    wait_neg(83); chk_disp("lz0.d0", 4'b1110, 7'b0000001, 1'b1);
    wait_neg(87); chk_disp("lz0.d1", 4'b1101, 7'h7F, 1'b1);
    wait_neg(91); chk_disp("lz0.d2", 4'b1011, 7'h7F, 1'b1);
    wait_neg(95); chk_disp("lz0.d3", 4'b0111, 7'h7F, 1'b1);

    // Reset while an update is pending discards it.
    data_in = 16'hBEEF; dp_in = 4'b1111; lz_en = 1'b0; load = 1'b1;
    wait_neg(96); load = 1'b0;
    chk("rstu.upd_set", 32'(upd_pending), 32'd1);
    rst_n = 1'b0;
    wait_neg(97);
    chk("rstu.upd", 32'(upd_pending), 32'd0);
    chk_disp("rstu.dark", 4'hF, 7'h7F, 1'b1);
    rst_n = 1'b1;
    wait_neg(100); chk_disp("rstu.dark3", 4'hF, 7'h7F, 1'b1);
    wait_neg(101); chk_disp("rstu.d1", 4'b1101, 7'b0000001, 1'b1);
    wait_neg(105); chk_disp("rstu.d2", 4'b1011, 7'b0000001, 1'b1);
    wait_neg(109); chk_disp("rstu.d3", 4'b0111, 7'b0000001, 1'b1);
    wait_neg(113);
    chk_disp("rstu.d0", 4'b1110, 7'b0000001, 1'b1);
    chk("rstu.upd_end", 32'(upd_pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
